conv_mac_unit: RTL and testbench
================================

CONV_MAC_UNIT -- requirements
Module: conv_mac_unit

Interface
REQ-001 Parameter DATA_BITS, 8, pixel and output width (unsigned).
REQ-002 Parameter FILTER_SIZE, 5, window side; window holds FILTER_SIZE*FILTER_SIZE = 25 taps.
REQ-003 Parameter WEIGHT_BITS, 8, signed weight and bias width.
REQ-004 Parameter ACC_BITS, 24, signed accumulator width.
REQ-005 Parameter OUT_SHIFT, 7, right-shift applied to the accumulator before saturation.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 in_val  input  1  window valid from the upstream window buffer.
REQ-009 window  input  25*DATA_BITS  tap a = row*5+col at bits [a*DATA_BITS +: DATA_BITS]; row 0 is the oldest line, rows 0-3 come from line storage and row 4 is the live row.
REQ-010 w_val  input  1  coefficient word valid.
REQ-011 w_data  input  WEIGHT_BITS  coefficient word, signed.
REQ-012 w_ready  output  1  high once a complete coefficient set is active.
REQ-013 out_val  output  1  result valid, single-cycle pulse per accepted window.
REQ-014 data_out  output  DATA_BITS  convolution result after ReLU and saturation.

Function
REQ-015 Coefficient load: 26 words per set; words 0-24 go to weight index 0-24 (same indexing as window taps); word 25 is the bias.
REQ-016 Loader states: LOAD (index 0-25 counting on w_val) and HOLD; a w_val in HOLD is taken as word 0 of a new set and enters LOAD.
REQ-017 Words are written to a shadow set; on the cycle word 25 is accepted, the shadow set is copied to the active set on the next edge and w_ready is set (it is never cleared except by reset).
REQ-018 Windows use only the active set; a reload in progress does not alter results for windows already accepted or accepted before the commit edge.
REQ-019 A window is accepted when in_val=1 and w_ready=1; windows with w_ready=0 are dropped with no output.
REQ-020 w_val and in_val in the same cycle are both honoured independently.
REQ-021 Stage 1: 25 products, pixel zero-extended to DATA_BITS+1 bits times signed weight, registered.
REQ-022 Stage 2: products summed in 5 row groups of 5, each sign-extended to ACC_BITS, registered.
REQ-023 Stage 3: sum of 5 row sums plus bias sign-extended and shifted left by OUT_SHIFT, ACC_BITS signed, registered.
REQ-024 Stage 4: if the sum is negative, data_out=0; otherwise sum arithmetic-shifted right by OUT_SHIFT, saturated to 2^DATA_BITS-1; registered.
REQ-025 Latency: out_val asserts exactly 4 cycles after the accepting edge; full throughput, one window per cycle, no stall input.
REQ-026 Valid bits travel with data through a 4-deep valid pipeline; data_out holds its last value when out_val=0.

Reset
REQ-027 On rst_n low: out_val=0, data_out=0, w_ready=0, loader in LOAD with index 0, valid pipeline cleared, active and shadow sets cleared to 0.
REQ-028 A reset mid-pipeline discards all in-flight windows; a reset mid-load discards the partial set.
REQ-029 After reset release, no out_val until a full 26-word set is committed and a window is accepted.

Structure
REQ-030 A shared package holds the tap count, coefficient-set length (26), loader state encoding, and the default widths.
REQ-031 One sub-module, conv_row_dot, computes one registered 5-tap row dot product (stages 1-2) and is instantiated FILTER_SIZE times.

Verification
REQ-032 Weights all 1, bias 0, window all 100 -> out_val 4 cycles later with data_out = 2500>>7 = 19.
REQ-033 Center weight (index 12) = 127, others 0, bias 0, center pixel 255, others 0 -> data_out = 32385>>7 = 253.
REQ-034 Weights all -1, window all 200 -> data_out = 0 (ReLU); weights all 127, window all 255 -> data_out = 255 (saturation).
REQ-035 Windows before load complete -> no out_val; 26th word accepted -> w_ready high next cycle; back-to-back windows -> out_val high for consecutive cycles.
REQ-036 Streaming windows while a second set (all weights 2) loads -> results switch from set 1 to set 2 exactly for windows accepted after the commit edge.
REQ-037 rst_n pulsed low with 3 windows in flight -> no out_val afterwards, w_ready=0, data_out=0.

Source files
------------

// File: rtl/conv_mac_unit_pkg.sv
// Shared constants and types for the 5x5 convolution MAC unit: default
// widths, tap/coefficient-set sizes and the coefficient loader states.
package conv_mac_unit_pkg;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_FILTER_SIZE = 5;
  localparam int DEF_WEIGHT_BITS = 8;
  localparam int DEF_ACC_BITS    = 24;
  localparam int DEF_OUT_SHIFT   = 7;

  // One bias word follows the weight words in every coefficient set.
  localparam int BIAS_WORDS = 1;
  localparam int TAPS       = DEF_FILTER_SIZE * DEF_FILTER_SIZE;
  localparam int SET_LEN    = TAPS + BIAS_WORDS;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } load_state_t;

endpackage

// File: rtl/conv_mac_unit_row_dot.sv
// One row of the convolution window: FILTER_SIZE pixel*weight products
// registered, then summed into a sign-extended row sum, registered.
module conv_row_dot
  import conv_mac_unit_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
  parameter int ACC_BITS    = DEF_ACC_BITS
) (
  input  logic                               clk,
  input  logic [FILTER_SIZE*DATA_BITS-1:0]   pix,
  input  logic [FILTER_SIZE*WEIGHT_BITS-1:0] wts,
  output logic [ACC_BITS-1:0]                row_sum
);

  // Unsigned pixel gets one extra zero bit so it multiplies as a signed value.
  localparam int PROD_W = DATA_BITS + 1 + WEIGHT_BITS;

  logic signed [PROD_W-1:0]   px_ext  [FILTER_SIZE];
  logic signed [PROD_W-1:0]   wt_ext  [FILTER_SIZE];
  logic signed [PROD_W-1:0]   prod_p1 [FILTER_SIZE];
  logic signed [ACC_BITS-1:0] sum_c;
  logic signed [ACC_BITS-1:0] row_p2;

  // Widen each tap to the product width, preserving sign.
  always_comb begin
    for (int k = 0; k < FILTER_SIZE; k++) begin
      px_ext[k] = PROD_W'(signed'({1'b0, pix[k*DATA_BITS +: DATA_BITS]}));
      wt_ext[k] = PROD_W'(signed'(wts[k*WEIGHT_BITS +: WEIGHT_BITS]));
    end
  end

  // Stage 1: per-tap products.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FILTER_SIZE; k++) begin
      prod_p1[k] <= px_ext[k] * wt_ext[k];
    end
  end

  // Add the row's products at accumulator width.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < FILTER_SIZE; k++) begin
      sum_c = sum_c + ACC_BITS'(prod_p1[k]);
    end
  end

  // Stage 2: registered row sum.
  always_ff @(posedge clk) begin
    row_p2 <= sum_c;
  end

  assign row_sum = row_p2;

endmodule

// File: rtl/conv_mac_unit.sv
// 5x5 convolution MAC: streams coefficient sets into a shadow store and
// commits them atomically, then runs each accepted window through a
// 4-stage multiply / row-sum / total+bias / ReLU-saturate pipeline.
module conv_mac_unit
  import conv_mac_unit_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
  parameter int ACC_BITS    = DEF_ACC_BITS,
  parameter int OUT_SHIFT   = DEF_OUT_SHIFT
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_val,
  input  logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window,
  input  logic                                         w_val,
  input  logic [WEIGHT_BITS-1:0]                       w_data,
  output logic                                         w_ready,
  output logic                                         out_val,
  output logic [DATA_BITS-1:0]                         data_out
);

  localparam int N_TAPS  = FILTER_SIZE * FILTER_SIZE;
  localparam int N_WORDS = N_TAPS + BIAS_WORDS;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int ROW_PIX = FILTER_SIZE * DATA_BITS;
  localparam int ROW_WTS = FILTER_SIZE * WEIGHT_BITS;
  localparam logic signed [ACC_BITS-1:0] OUT_MAX = ACC_BITS'((1 << DATA_BITS) - 1);

  // ReLU, scale down by OUT_SHIFT, clamp to the unsigned output range.
  function automatic logic [DATA_BITS-1:0] relu_sat(input logic signed [ACC_BITS-1:0] acc);
    logic signed [ACC_BITS-1:0] scaled;
    if (acc < 0) begin
      return '0;
    end
    scaled = acc >>> OUT_SHIFT;
    if (scaled > OUT_MAX) begin
      return '1;
    end
    return scaled[DATA_BITS-1:0];
  endfunction

  load_state_t                state;
  logic [IDX_W-1:0]           idx;
  logic signed [WEIGHT_BITS-1:0] shadow     [N_TAPS];
  logic signed [WEIGHT_BITS-1:0] weight_act [N_TAPS];
  logic signed [WEIGHT_BITS-1:0] bias_act;

  logic                       accept;
  logic [N_TAPS*WEIGHT_BITS-1:0] wts_flat;

  logic signed [WEIGHT_BITS-1:0] bias_p1;
  logic signed [WEIGHT_BITS-1:0] bias_p2;
  logic signed [ACC_BITS-1:0]    row_sum_p2 [FILTER_SIZE];
  logic signed [ACC_BITS-1:0]    total_c;
  logic signed [ACC_BITS-1:0]    total_p3;
  logic vld_p1, vld_p2, vld_p3, vld_p4;

  assign accept = in_val & w_ready;

  // Coefficient loader: collect words into the shadow set; the bias word
  // completes the set and commits weights plus bias to the active set at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      idx      <= '0;
      w_ready  <= 1'b0;
      bias_act <= '0;
      for (int a = 0; a < N_TAPS; a++) begin
        shadow[a]     <= '0;
        weight_act[a] <= '0;
      end
    end else if (w_val) begin
      if (state == HOLD) begin
        shadow[0] <= w_data;
        idx       <= IDX_W'(1);
        state     <= LOAD;
      end else if (idx == IDX_W'(N_TAPS)) begin
        for (int a = 0; a < N_TAPS; a++) begin
          weight_act[a] <= shadow[a];
        end
        bias_act <= w_data;
        w_ready  <= 1'b1;
        idx      <= '0;
        state    <= HOLD;
      end else begin
        shadow[idx] <= w_data;
        idx         <= idx + IDX_W'(1);
      end
    end
  end

  // Flatten the active weights in window-tap order for the row units.
  always_comb begin
    wts_flat = '0;
    for (int a = 0; a < N_TAPS; a++) begin
      wts_flat[a*WEIGHT_BITS +: WEIGHT_BITS] = weight_act[a];
    end
  end

  // ---- Stages 1-2: products and row sums, one unit per window row ----
  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    conv_row_dot #(
      .DATA_BITS  (DATA_BITS),
      .FILTER_SIZE(FILTER_SIZE),
      .WEIGHT_BITS(WEIGHT_BITS),
      .ACC_BITS   (ACC_BITS)
    ) u_row (
      .clk    (clk),
      .pix    (window[r*ROW_PIX +: ROW_PIX]),
      .wts    (wts_flat[r*ROW_WTS +: ROW_WTS]),
      .row_sum(row_sum_p2[r])
    );
  end

  // Bias rides alongside its window so a commit never splits a result.
  always_ff @(posedge clk) begin
    bias_p1 <= bias_act;
    bias_p2 <= bias_p1;
  end

  // Combine row sums with the bias aligned to the pre-shift scale.
  always_comb begin
    total_c = ACC_BITS'(bias_p2) <<< OUT_SHIFT;
    for (int r = 0; r < FILTER_SIZE; r++) begin
      total_c = total_c + row_sum_p2[r];
    end
  end

  // ---- Stage 3: registered total ----
  always_ff @(posedge clk) begin
    total_p3 <= total_c;
  end

  // Valid bits shadow the data stages; cleared by reset to drop in-flight windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  // ---- Stage 4: ReLU/saturate; output holds between results ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (vld_p3) begin
      data_out <= relu_sat(total_p3);
    end
  end

  assign out_val = vld_p4;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Scoreboard bench for conv_mac_unit: stimulus pushes expected results,
// a negedge monitor pops and compares them when out_val is seen.
module tb_conv_mac_unit;
  import conv_mac_unit_pkg::*;

  localparam int DB   = 8;
  localparam int WB   = 8;
  localparam int SH   = 7;
  localparam int OMAX = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_val;
  logic [TAPS*DB-1:0] window;
  logic              w_val;
  logic [WB-1:0]     w_data;
  logic              w_ready;
  logic              out_val;
  logic [DB-1:0]     data_out;

  conv_mac_unit #(
    .DATA_BITS  (DB),
    .FILTER_SIZE(5),
    .WEIGHT_BITS(WB),
    .ACC_BITS   (24),
    .OUT_SHIFT  (SH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (in_val),
    .window  (window),
    .w_val   (w_val),
    .w_data  (w_data),
    .w_ready (w_ready),
    .out_val (out_val),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    val;
    int    due;
    string tag;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: word counter into the set being loaded.
  int m_w  [TAPS];
  int m_b;
  int m_sh [SET_LEN];
  int m_cnt;
  bit m_ready;

  int idle_px[TAPS];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_out(input int px[TAPS], input int w[TAPS], input int b);
    longint acc;
    acc = longint'(b) * (1 << SH);
    for (int a = 0; a < TAPS; a++) acc += longint'(px[a]) * w[a];
    if (acc < 0) return 0;
    acc = acc / (1 << SH);
    if (acc > OMAX) return OMAX;
    return int'(acc);
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_b     = 0;
    for (int a = 0; a < TAPS; a++) m_w[a] = 0;
    sb.delete();
  endtask

  // Present one cycle of inputs and advance the model by the same cycle.
  task automatic step(input bit iv, input int px[TAPS], input bit wv, input int wd,
                      input int fixed_exp, input string tag);
    @(posedge clk);
    #1;
    in_val = iv;
    w_val  = wv;
    w_data = wd[WB-1:0];
    for (int a = 0; a < TAPS; a++) window[a*DB +: DB] = px[a][DB-1:0];
    if (iv && m_ready)
      sb.push_back('{(fixed_exp >= 0) ? fixed_exp : ref_out(px, m_w, m_b), cyc + 4, tag});
    if (wv) begin
      m_sh[m_cnt] = wd;
      if (m_cnt == SET_LEN - 1) begin
        for (int a = 0; a < TAPS; a++) m_w[a] = m_sh[a];
        m_b     = m_sh[TAPS];
        m_ready = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, idle_px, 1'b0, 0, -1, "idle");
  endtask

  task automatic rand_window(output int px[TAPS]);
    for (int a = 0; a < TAPS; a++) px[a] = int'($urandom_range(0, 255));
  endtask

  task automatic load_set(input int ws[SET_LEN], input bit stream, input bit gaps, input bit first);
    int sent;
    bit wv;
    bit iv;
    int px[TAPS];
    sent = 0;
    while (sent < SET_LEN) begin
      wv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      iv = stream;
      rand_window(px);
      step(iv, px, wv, wv ? ws[sent] : 0, -1, "during_load");
      if (wv) sent++;
    end
    if (first) check("w_ready_before_commit", w_ready, 0);
  endtask

  // Monitor: compare each result against the oldest expectation; flag
  // expectations whose due cycle has passed without an out_val.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check({"missing_out_val_", sb[0].tag}, 0, 1);
        void'(sb.pop_front());
      end
      if (out_val) begin
        if (sb.size() == 0) begin
          check("unexpected_out_val", 1, 0);
        end else begin
          check({"data_out_", sb[0].tag}, data_out, sb[0].val);
          check({"latency_", sb[0].tag}, cyc, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int ws[SET_LEN];
    int px[TAPS];

    rst_n  = 1'b0;
    in_val = 1'b0;
    w_val  = 1'b0;
    w_data = '0;
    window = '0;
    for (int a = 0; a < TAPS; a++) idle_px[a] = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_val", out_val, 0);
    check("reset_data_out", data_out, 0);
    check("reset_w_ready", w_ready, 0);
    rst_n = 1'b1;

    // Windows before any coefficients are dropped.
    for (int i = 0; i < 4; i++) begin
      rand_window(px);
      step(1'b1, px, 1'b0, 0, -1, "drop");
    end
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("no_out_before_load", out_val, 0);
    end

    // Set 1: all weights 1, bias 0.
    for (int a = 0; a < TAPS; a++) ws[a] = 1;
    ws[TAPS] = 0;
    load_set(ws, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("w_ready_after_commit", w_ready, 1);

    for (int a = 0; a < TAPS; a++) px[a] = 100;
    step(1'b1, px, 1'b0, 0, 19, "all100");
    step(1'b1, px, 1'b0, 0, 19, "all100_b2b");
    step(1'b1, px, 1'b0, 0, 19, "all100_b2b");
    idle(6);

    // Center tap only.
    for (int a = 0; a < TAPS; a++) ws[a] = 0;
    ws[12] = 127;
    ws[TAPS] = 0;
    load_set(ws, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < TAPS; a++) px[a] = 0;
    px[12] = 255;
    step(1'b1, px, 1'b0, 0, 253, "center");
    idle(6);

    // Negative sum clamps to zero.
    for (int a = 0; a < TAPS; a++) ws[a] = -1;
    ws[TAPS] = 0;
    load_set(ws, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < TAPS; a++) px[a] = 200;
    step(1'b1, px, 1'b0, 0, 0, "relu");
    idle(6);

    // Large sum saturates.
    for (int a = 0; a < TAPS; a++) ws[a] = 127;
    ws[TAPS] = 0;
    load_set(ws, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < TAPS; a++) px[a] = 255;
    step(1'b1, px, 1'b0, 0, 255, "saturate");
    idle(6);

    // Random set loaded with gaps while windows stream on the old set.
    for (int a = 0; a < TAPS; a++) ws[a] = int'($urandom_range(0, 32)) - 16;
    ws[TAPS] = int'($urandom_range(0, 255)) - 128;
    load_set(ws, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rand_window(px);
      step($urandom_range(0, 3) != 0, px, 1'b0, 0, -1, "random");
    end

    // Switch to all-2 weights while streaming every cycle.
    for (int a = 0; a < TAPS; a++) ws[a] = 2;
    ws[TAPS] = 0;
    load_set(ws, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rand_window(px);
      step(1'b1, px, 1'b0, 0, -1, "after_switch");
    end
    idle(8);
    check("scoreboard_drained", sb.size(), 0);

    // Reset with three windows in flight.
    for (int i = 0; i < 3; i++) begin
      rand_window(px);
      step(1'b1, px, 1'b0, 0, -1, "inflight");
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("no_out_after_reset", out_val, 0);
    end
    check("w_ready_after_reset", w_ready, 0);
    check("data_out_after_reset", data_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
